// File: rtl/ftdi_bridge_pkg.sv
// Shared types and byte constants for the FT245 register bridge.
package ftdi_bridge_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_W_ADDR,
    S_R_ADDR,
    S_W_DATA,
    S_WRITE,
    S_READ,
    S_R_WAIT,
    S_RESP
  } state_e;

  localparam logic [7:0] CMD_WR  = 8'h57;
  localparam logic [7:0] CMD_RD  = 8'h52;

  localparam logic [7:0] RSP_WR  = 8'h4B;
  localparam logic [7:0] RSP_RD  = 8'h72;
  localparam logic [7:0] RSP_ERR = 8'h65;

  localparam logic [2:0] LEN_WR  = 3'd2;
  localparam logic [2:0] LEN_RD  = 3'd6;

  // States in which the bridge is willing to take a host byte.
  function automatic logic rx_open(input state_e s);
    return (s == S_IDLE) || (s == S_W_ADDR) || (s == S_R_ADDR) || (s == S_W_DATA);
  endfunction

endpackage

// File: rtl/ftdi_tx_serializer.sv
// Shifts a response frame (byte 0 in bits [7:0]) out over the tx handshake.
module ftdi_tx_serializer (
  input  logic        clk,
  input  logic        resetn,
  input  logic        load,
  input  logic [47:0] resp,
  input  logic [2:0]  len,
  input  logic        tx_rdy,
  output logic [7:0]  tx_din,
  output logic        tx_dv_in,
  output logic        busy
);

  logic [47:0] shift_q;
  logic [2:0]  cnt_q;
  logic        dv_q;

  // Load a frame, then advance one byte per accepted handshake; the last byte is held.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      shift_q <= '0;
      cnt_q   <= '0;
      dv_q    <= 1'b0;
    end else if (load) begin
      shift_q <= resp;
      cnt_q   <= len;
      dv_q    <= 1'b1;
    end else if (dv_q && tx_rdy) begin
      cnt_q <= cnt_q - 3'd1;
      if (cnt_q == 3'd1) begin
        dv_q <= 1'b0;
      end else begin
        shift_q <= {8'h00, shift_q[47:8]};
      end
    end
  end

  assign tx_din   = shift_q[7:0];
  assign tx_dv_in = dv_q;
  assign busy     = dv_q;

endmodule

// File: rtl/ftdi_reg_bridge.sv
// Parses host read/write frames into register bus strobes and returns responses.
//
// state    | meaning
// ---------+--------------------------------------------------
// S_IDLE   | waiting for a command byte; unknown bytes dropped
// S_W_ADDR | write frame, expecting address byte
// S_R_ADDR | read frame, expecting address byte
// S_W_DATA | write frame, collecting d0..d3 (little-endian)
// S_WRITE  | one-cycle reg_we, load write acknowledge
// S_READ   | one-cycle reg_re
// S_R_WAIT | waiting for reg_rvalid or read timeout
// S_RESP   | response bytes draining through the serializer
module ftdi_reg_bridge
  import ftdi_bridge_pkg::*;
#(
  parameter int RX_TIMEOUT = 1024,
  parameter int RD_TIMEOUT = 256
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [7:0]  rx_dout,
  input  logic        rx_dv_out,
  output logic        rx_rdy,
  output logic [7:0]  tx_din,
  output logic        tx_dv_in,
  input  logic        tx_rdy,
  output logic [7:0]  reg_addr,
  output logic [31:0] reg_wdata,
  output logic        reg_we,
  output logic        reg_re,
  input  logic [31:0] reg_rdata,
  input  logic        reg_rvalid,
  output logic [7:0]  err_count
);

  localparam int RX_TW = $clog2(RX_TIMEOUT + 1);
  localparam int RD_TW = $clog2(RD_TIMEOUT + 1);
  localparam logic [RX_TW-1:0] RX_TMR_MAX = RX_TW'(RX_TIMEOUT - 1);
  localparam logic [RD_TW-1:0] RD_TMR_MAX = RD_TW'(RD_TIMEOUT - 1);

  state_e            state_q, state_d;
  logic              rx_rdy_q, rx_rdy_d;
  logic              reg_we_q, reg_we_d;
  logic              reg_re_q, reg_re_d;
  logic [7:0]        addr_q;
  logic [31:0]       wdata_q;
  logic [1:0]        idx_q;
  logic [RX_TW-1:0]  rx_tmr_q;
  logic [RD_TW-1:0]  rd_tmr_q;
  logic [7:0]        err_q;

  logic              rx_acc, in_frame, rx_tmo, rd_tmo, err_inc;
  logic              ser_load, ser_busy;
  logic [47:0]       ser_resp;
  logic [2:0]        ser_len;

  assign rx_acc   = rx_dv_out && rx_rdy_q;
  assign in_frame = (state_q == S_W_ADDR) || (state_q == S_R_ADDR) || (state_q == S_W_DATA);
  assign rx_tmo   = in_frame && !rx_acc && (rx_tmr_q == '0);
  assign rd_tmo   = (state_q == S_R_WAIT) && !reg_rvalid && (rd_tmr_q == '0);

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // Next-state decode; an accepted byte always beats an expiring timer.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (rx_acc && rx_dout == CMD_WR)      state_d = S_W_ADDR;
        else if (rx_acc && rx_dout == CMD_RD) state_d = S_R_ADDR;
      end
      S_W_ADDR: begin
        if (rx_acc)      state_d = S_W_DATA;
        else if (rx_tmo) state_d = S_IDLE;
      end
      S_R_ADDR: begin
        if (rx_acc)      state_d = S_READ;
        else if (rx_tmo) state_d = S_IDLE;
      end
      S_W_DATA: begin
        if (rx_acc && idx_q == 2'd3) state_d = S_WRITE;
        else if (rx_tmo)             state_d = S_IDLE;
      end
      S_WRITE:  state_d = S_RESP;
      S_READ:   state_d = S_R_WAIT;
      S_R_WAIT: if (reg_rvalid || rd_tmo) state_d = S_RESP;
      S_RESP:   if (!ser_busy) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Output decode: registered strobes follow the next state, responses load from the current one.
  always_comb begin
    rx_rdy_d = rx_open(state_d);
    reg_we_d = (state_d == S_WRITE);
    reg_re_d = (state_d == S_READ);
    ser_load = 1'b0;
    ser_resp = '0;
    ser_len  = LEN_WR;
    err_inc  = 1'b0;
    case (state_q)
      S_IDLE:   err_inc = rx_acc && (rx_dout != CMD_WR) && (rx_dout != CMD_RD);
      S_W_ADDR, S_R_ADDR, S_W_DATA: err_inc = rx_tmo;
      S_WRITE: begin
        ser_load = 1'b1;
        ser_resp = {32'h0, addr_q, RSP_WR};
        ser_len  = LEN_WR;
      end
      S_R_WAIT: begin
        if (reg_rvalid) begin
          ser_load = 1'b1;
          ser_resp = {reg_rdata, addr_q, RSP_RD};
          ser_len  = LEN_RD;
        end else if (rd_tmo) begin
          ser_load = 1'b1;
          ser_resp = {32'h0, addr_q, RSP_ERR};
          ser_len  = LEN_RD;
          err_inc  = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Datapath: address/data capture, down-counting timers, saturating error counter.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rx_rdy_q <= 1'b0;
      reg_we_q <= 1'b0;
      reg_re_q <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      idx_q    <= '0;
      rx_tmr_q <= '0;
      rd_tmr_q <= '0;
      err_q    <= '0;
    end else begin
      rx_rdy_q <= rx_rdy_d;
      reg_we_q <= reg_we_d;
      reg_re_q <= reg_re_d;
      if (rx_acc && (state_q == S_W_ADDR || state_q == S_R_ADDR)) addr_q <= rx_dout;
      if (state_q != S_W_DATA) begin
        idx_q <= 2'd0;
      end else if (rx_acc) begin
        wdata_q[{idx_q, 3'b000} +: 8] <= rx_dout;
        idx_q <= idx_q + 2'd1;
      end
      if (rx_acc)                           rx_tmr_q <= RX_TMR_MAX;
      else if (in_frame && rx_tmr_q != '0)  rx_tmr_q <= rx_tmr_q - 1'b1;
      if (state_q == S_READ)                          rd_tmr_q <= RD_TMR_MAX;
      else if (state_q == S_R_WAIT && rd_tmr_q != '0) rd_tmr_q <= rd_tmr_q - 1'b1;
      if (err_inc && err_q != 8'hFF) err_q <= err_q + 8'd1;
    end
  end

  ftdi_tx_serializer u_ser (
    .clk      (clk),
    .resetn   (resetn),
    .load     (ser_load),
    .resp     (ser_resp),
    .len      (ser_len),
    .tx_rdy   (tx_rdy),
    .tx_din   (tx_din),
    .tx_dv_in (tx_dv_in),
    .busy     (ser_busy)
  );

  assign rx_rdy    = rx_rdy_q;
  assign reg_we    = reg_we_q;
  assign reg_re    = reg_re_q;
  assign reg_addr  = addr_q;
  assign reg_wdata = wdata_q;
  assign err_count = err_q;

endmodule

// File: tb/tb_ftdi_reg_bridge.sv
// Directed bench for ftdi_reg_bridge: table of frames plus hand-written corner sequences.
module tb_ftdi_reg_bridge;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [7:0]  rx_dout = 8'h00;
  logic        rx_dv_out = 1'b0;
  logic        rx_rdy;
  logic [7:0]  tx_din;
  logic        tx_dv_in;
  logic        tx_rdy;
  logic [7:0]  reg_addr;
  logic [31:0] reg_wdata;
  logic        reg_we;
  logic        reg_re;
  logic [31:0] reg_rdata;
  logic        reg_rvalid;
  logic [7:0]  err_count;

  always #5 clk = ~clk;

  ftdi_reg_bridge dut (
    .clk        (clk),
    .resetn     (resetn),
    .rx_dout    (rx_dout),
    .rx_dv_out  (rx_dv_out),
    .rx_rdy     (rx_rdy),
    .tx_din     (tx_din),
    .tx_dv_in   (tx_dv_in),
    .tx_rdy     (tx_rdy),
    .reg_addr   (reg_addr),
    .reg_wdata  (reg_wdata),
    .reg_we     (reg_we),
    .reg_re     (reg_re),
    .reg_rdata  (reg_rdata),
    .reg_rvalid (reg_rvalid),
    .err_count  (err_count)
  );

  int checks = 0;
  int failures = 0;

  logic        tx_random = 1'b0;
  logic        rd_respond = 1'b0;
  logic [31:0] rd_value = 32'h0;

  logic [7:0]  txq[$];
  int          tx_rd = 0;
  int          we_cnt = 0;
  int          re_cnt = 0;
  logic [7:0]  we_addr = 8'h00;
  logic [31:0] we_data = 32'h0;

  // Observe the bus at the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (tx_dv_in && tx_rdy) txq.push_back(tx_din);
    if (reg_we) begin
      we_cnt++;
      we_addr = reg_addr;
      we_data = reg_wdata;
    end
    if (reg_re) re_cnt++;
  end

  initial begin
    tx_rdy = 1'b1;
    forever begin
      @(posedge clk); #1;
      tx_rdy = tx_random ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Register model: answers a read strobe three cycles later with a one-cycle valid.
  initial begin
    reg_rvalid = 1'b0;
    reg_rdata  = 32'h0;
    forever begin
      @(negedge clk);
      if (reg_re && rd_respond) begin
        repeat (3) @(posedge clk);
        #1;
        reg_rvalid = 1'b1;
        reg_rdata  = rd_value;
        @(posedge clk); #1;
        reg_rvalid = 1'b0;
        reg_rdata  = 32'h0;
      end
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog expired actual=running required=finished");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    rx_dout   = b;
    rx_dv_out = 1'b1;
    while (!rx_rdy && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 200) begin
      checks++;
      failures++;
      $display("FAIL rx_handshake actual=rx_rdy_low required=rx_rdy_high byte=0x%0h", b);
    end
    @(posedge clk); #1;
    rx_dv_out = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Wait for len response bytes, then confirm nothing extra follows. exp is in wire order, MSB first.
  task automatic wait_tx(input string nm, input int len, input logic [47:0] exp, input int budget);
    int n;
    n = 0;
    while (txq.size() < tx_rd + len && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    idle(4);
    chk({nm, "_len"}, 64'(txq.size() - tx_rd), 64'(len));
    for (int i = 0; i < len; i++) begin
      if (tx_rd + i < txq.size())
        chk($sformatf("%s_b%0d", nm, i), 64'(txq[tx_rd + i]), 64'(exp[47 - 8*i -: 8]));
    end
    tx_rd = txq.size();
  endtask

  typedef struct {
    logic        is_wr;
    logic [7:0]  addr;
    logic [31:0] data;
    logic        respond;
    int          rlen;
    logic [47:0] resp;
    int          err_inc;
  } vec_t;

  vec_t vecs[5];

  int          exp_err;
  logic [31:0] last_wd;
  int          we0, re0;

  initial begin
    vecs[0] = '{1'b1, 8'h10, 32'hDEADBEEF, 1'b0, 2, 48'h4B10_0000_0000, 0};
    vecs[1] = '{1'b0, 8'h22, 32'h12345678, 1'b1, 6, 48'h7222_7856_3412, 0};
    vecs[2] = '{1'b0, 8'h05, 32'h00000000, 1'b0, 6, 48'h6505_0000_0000, 1};
    vecs[3] = '{1'b1, 8'hFF, 32'h00000001, 1'b0, 2, 48'h4BFF_0000_0000, 0};
    vecs[4] = '{1'b0, 8'hFF, 32'hA5A50F0F, 1'b1, 6, 48'h72FF_0F0F_A5A5, 0};
    exp_err = 0;
    last_wd = 32'h0;

    idle(3);
    chk("rst_rx_rdy",    64'(rx_rdy),    64'h0);
    chk("rst_tx_dv_in",  64'(tx_dv_in),  64'h0);
    chk("rst_reg_we",    64'(reg_we),    64'h0);
    chk("rst_reg_re",    64'(reg_re),    64'h0);
    chk("rst_tx_din",    64'(tx_din),    64'h0);
    chk("rst_reg_addr",  64'(reg_addr),  64'h0);
    chk("rst_reg_wdata", 64'(reg_wdata), 64'h0);
    chk("rst_err_count", 64'(err_count), 64'h0);
    resetn = 1'b1;
    idle(2);

    for (int v = 0; v < 5; v++) begin
      we0 = we_cnt;
      re0 = re_cnt;
      rd_respond = vecs[v].respond;
      rd_value   = vecs[v].data;
      if (vecs[v].is_wr) begin
        send_byte(8'h57);
        send_byte(vecs[v].addr);
        for (int k = 0; k < 4; k++) send_byte(vecs[v].data[8*k +: 8]);
      end else begin
        send_byte(8'h52);
        send_byte(vecs[v].addr);
      end
      wait_tx($sformatf("vec%0d_tx", v), vecs[v].rlen, vecs[v].resp, 600);
      exp_err += vecs[v].err_inc;
      chk($sformatf("vec%0d_err", v), 64'(err_count), 64'(exp_err));
      chk($sformatf("vec%0d_addr", v), 64'(reg_addr), 64'(vecs[v].addr));
      if (vecs[v].is_wr) begin
        chk($sformatf("vec%0d_we_pulses", v), 64'(we_cnt - we0), 64'd1);
        chk($sformatf("vec%0d_re_pulses", v), 64'(re_cnt - re0), 64'd0);
        chk($sformatf("vec%0d_we_addr", v),   64'(we_addr), 64'(vecs[v].addr));
        chk($sformatf("vec%0d_we_data", v),   64'(we_data), 64'(vecs[v].data));
        last_wd = vecs[v].data;
      end else begin
        chk($sformatf("vec%0d_re_cycles", v), 64'(re_cnt - re0), 64'd1);
        chk($sformatf("vec%0d_we_pulses", v), 64'(we_cnt - we0), 64'd0);
        chk($sformatf("vec%0d_wdata_hold", v), 64'(reg_wdata), 64'(last_wd));
      end
    end

    // Unknown byte in IDLE is dropped and counted; the following read still works.
    we0 = we_cnt;
    send_byte(8'h41);
    idle(2);
    exp_err++;
    chk("bad_byte_err", 64'(err_count), 64'(exp_err));
    chk("bad_byte_no_tx", 64'(txq.size() - tx_rd), 64'd0);
    rd_respond = 1'b1;
    rd_value   = 32'hCAFEF00D;
    send_byte(8'h52);
    send_byte(8'h33);
    wait_tx("bad_then_rd", 6, 48'h7233_0DF0_FECA, 200);
    chk("bad_then_rd_err", 64'(err_count), 64'(exp_err));
    chk("idle_rx_rdy", 64'(rx_rdy), 64'h1);

    // A long but sub-threshold gap inside a write frame must not abort it.
    we0 = we_cnt;
    send_byte(8'h57);
    send_byte(8'h60);
    send_byte(8'h01);
    send_byte(8'h02);
    idle(1000);
    send_byte(8'h03);
    send_byte(8'h04);
    wait_tx("gap_wr", 2, 48'h4B60_0000_0000, 200);
    chk("gap_wr_we",   64'(we_cnt - we0), 64'd1);
    chk("gap_wr_data", 64'(we_data), 64'h04030201);
    chk("gap_wr_err",  64'(err_count), 64'(exp_err));

    // Stalled write frame is abandoned after the inter-byte timeout.
    we0 = we_cnt;
    send_byte(8'h57);
    send_byte(8'h10);
    send_byte(8'hAA);
    idle(1030);
    exp_err++;
    chk("rx_tmo_no_we", 64'(we_cnt - we0), 64'd0);
    chk("rx_tmo_no_tx", 64'(txq.size() - tx_rd), 64'd0);
    chk("rx_tmo_err",   64'(err_count), 64'(exp_err));
    chk("rx_tmo_rx_rdy", 64'(rx_rdy), 64'h1);
    rd_value = 32'h0BADC0DE;
    send_byte(8'h52);
    send_byte(8'h10);
    wait_tx("rx_tmo_then_rd", 6, 48'h7210_DEC0_AD0B, 200);

    // Read response under a randomly throttled tx_rdy.
    tx_random = 1'b1;
    rd_value  = 32'h89ABCDEF;
    send_byte(8'h52);
    send_byte(8'h44);
    wait_tx("rand_tx_rd", 6, 48'h7244_EFCD_AB89, 400);
    tx_random = 1'b0;
    idle(2);

    // Error counter saturates rather than wrapping.
    for (int k = 0; k < 260; k++) begin
      send_byte(8'h00);
      if (exp_err < 255) exp_err++;
    end
    idle(2);
    chk("err_saturate", 64'(err_count), 64'(exp_err));

    // Reset in the middle of a write frame, then a clean frame parses from its command byte.
    send_byte(8'h57);
    send_byte(8'h20);
    send_byte(8'h11);
    resetn = 1'b0;
    #2;
    chk("mid_rst_rx_rdy",    64'(rx_rdy),    64'h0);
    chk("mid_rst_tx_dv_in",  64'(tx_dv_in),  64'h0);
    chk("mid_rst_tx_din",    64'(tx_din),    64'h0);
    chk("mid_rst_reg_addr",  64'(reg_addr),  64'h0);
    chk("mid_rst_reg_wdata", 64'(reg_wdata), 64'h0);
    chk("mid_rst_err_count", 64'(err_count), 64'h0);
    idle(2);
    resetn = 1'b1;
    exp_err = 0;
    idle(1);
    chk("post_rst_no_tx", 64'(txq.size() - tx_rd), 64'd0);
    we0 = we_cnt;
    send_byte(8'h57);
    send_byte(8'h30);
    send_byte(8'h04);
    send_byte(8'h03);
    send_byte(8'h02);
    send_byte(8'h01);
    wait_tx("post_rst_wr", 2, 48'h4B30_0000_0000, 200);
    chk("post_rst_we",      64'(we_cnt - we0), 64'd1);
    chk("post_rst_we_addr", 64'(we_addr), 64'h30);
    chk("post_rst_we_data", 64'(we_data), 64'h01020304);
    chk("post_rst_err",     64'(err_count), 64'(exp_err));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ftdi_reg_bridge.md
Name: ftdi_reg_bridge

Overview:
- Command-decoding stage directly downstream of the FT245 synchronous-FIFO interface (ftdi_if). Runs in the ftdi_clk domain.
- Consumes the host byte stream (rx_dout/rx_dv_out/rx_rdy) and parses read/write frames. Drives a simple 32-bit register bus with an 8-bit address.
- Returns response frames through the tx port (tx_din/tx_dv_in/tx_rdy), so the host can access on-chip registers over USB.

Parameters:
- RX_TIMEOUT, 1024, max cycles between bytes of one frame before the frame is aborted.
- RD_TIMEOUT, 256, max cycles waited for reg_rvalid after reg_re.

Ports:
- clk  in  1  ftdi_clk domain (60 MHz).
- resetn  in  1  asynchronous, active-low reset.
- rx_dout  in  8  received byte from ftdi_if.
- rx_dv_out  in  1  rx_dout valid.
- rx_rdy  out  1  bridge can accept a byte. A byte transfers when rx_dv_out && rx_rdy.
- tx_din  out  8  response byte to ftdi_if.
- tx_dv_in  out  1  tx_din valid. A byte transfers when tx_dv_in && tx_rdy.
- tx_rdy  in  1  ftdi_if can accept a tx byte.
- reg_addr  out  8  register address.
- reg_wdata  out  32  write data.
- reg_we  out  1  one-cycle write strobe.
- reg_re  out  1  one-cycle read strobe.
- reg_rdata  in  32  read data, valid with reg_rvalid.
- reg_rvalid  in  1  read data valid.
- err_count  out  8  saturating count of protocol errors.

Behaviour:

Frame formats (host to FPGA):
- Write: 0x57, addr, d0, d1, d2, d3. Data is little-endian: d0 = bits [7:0].
- Read: 0x52, addr.

Responses (FPGA to host):
- Write: 0x4B, addr.
- Read OK: 0x72, addr, d0..d3.
- Read timeout: 0x65, addr, 0x00 x4.

Reset values:
- rx_rdy, tx_dv_in, reg_we, reg_re = 0.
- tx_din, reg_addr, reg_wdata, err_count = 0.
- FSM enters IDLE. Asserting reset mid-frame or mid-response aborts immediately; no partial response is resumed.

FSM:
- IDLE: rx_rdy=1.
  - Accepted 0x57 -> W_ADDR.
  - Accepted 0x52 -> R_ADDR.
  - Any other accepted byte is consumed and dropped, err_count+1, stay IDLE.
- W_ADDR / R_ADDR: rx_rdy=1. Accepted byte is latched into reg_addr.
  - W_ADDR -> W_DATA with byte index = 0.
  - R_ADDR -> READ.
- W_DATA: rx_rdy=1. Each accepted byte is placed into reg_wdata[8*idx+:8]. After idx 3 -> WRITE.
- WRITE: single cycle. reg_we=1, rx_rdy=0. Response loaded -> RESP.
  - reg_we rises on the cycle after the d3 handshake.
- READ: single cycle. reg_re=1, rx_rdy=0 -> R_WAIT.
- R_WAIT: rx_rdy=0. reg_rvalid is ignored during the reg_re cycle, so the earliest sample is one cycle later.
  - On reg_rvalid: latch reg_rdata, load Read OK response -> RESP.
  - After RD_TIMEOUT cycles without reg_rvalid: load timeout response, err_count+1 -> RESP.
- RESP: rx_rdy=0, tx_dv_in=1. tx_din holds the current byte until the tx handshake, then advances.
  - After the last byte handshake, tx_dv_in drops on the next cycle -> IDLE.
  - tx_rdy low may stall indefinitely; no timeout applies in RESP.

Inter-byte timeout:
- Counter is cleared on every accepted rx byte and runs only in W_ADDR, R_ADDR and W_DATA.
- Reaching RX_TIMEOUT -> IDLE, err_count+1, no response sent.

Other rules:
- rx_rdy is registered: it is a function of state only and never depends combinationally on rx_dv_out.
- At most one error event occurs per cycle. err_count saturates at 255 and does not wrap.
- reg_addr and reg_wdata hold their values until overwritten by a later frame.

Decomposition:
- Package ftdi_bridge_pkg holds:
  - the state enum;
  - command constants CMD_WR=8'h57, CMD_RD=8'h52;
  - response constants RSP_WR=8'h4B, RSP_RD=8'h72, RSP_ERR=8'h65.
- Sub-module ftdi_tx_serializer:
  - inputs: load, 48-bit response vector, length (2 or 6);
  - outputs: tx_din/tx_dv_in, busy;
  - shifts bytes out under the tx_rdy handshake.

Test Plan:
1. Write frame 57 10 EF BE AD DE with tx_rdy=1 -> reg_we pulses once with reg_addr=0x10, reg_wdata=0xDEADBEEF; tx emits 4B 10.
2. Read frame 52 22; register model returns 0x12345678 three cycles after reg_re -> tx emits 72 22 78 56 34 12; reg_re is high exactly one cycle.
3. Read frame 52 05 with no reg_rvalid -> after 256 cycles, tx emits 65 05 00 00 00 00 and err_count=1.
4. Byte 0x41 in IDLE, followed by a valid read -> 0x41 dropped, err_count=1, read completes normally.
5. Send 57 10 AA, then idle 1024 cycles -> no reg_we, no tx output, err_count+1; the next 52 10 frame is accepted.
6. tx_rdy toggling randomly during a read response, plus resetn asserted mid-write-frame -> all 6 bytes arrive in order with no duplicates; after reset, outputs are at reset values and the next frame parses from its command byte.
